// File: rtl/dot_product_mac_pkg.sv
// Shared definitions for the dot-product MAC and the matrix multiplier controller.
// Holds the FSM state encoding, default widths and default accumulator limits.
// No logic; imported by every MAC source file.
package dot_product_mac_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 64;
    localparam int DEF_LEN_WIDTH  = 8;

    // Limits of the default-width accumulator; the MAC derives its own from ACC_WIDTH.
    localparam logic [DEF_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
    localparam logic [DEF_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_mult_reg.sv
// Registered signed DATA_WIDTH x DATA_WIDTH multiply with a valid bit carried alongside.
// Latency: 1 cycle from op_vld to prod_vld.
// No backpressure: every valid operand pair is registered unconditionally.
module mac_mult_reg
    import dot_product_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           op_vld,
    input  logic signed [DATA_WIDTH-1:0]   op_a,
    input  logic signed [DATA_WIDTH-1:0]   op_b,
    output logic                           prod_vld,
    output logic signed [2*DATA_WIDTH-1:0] prod_dat
);

    // Full-precision product; operands widened first so no bits are lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_vld <= 1'b0;
            prod_dat <= '0;
        end else begin
            prod_vld <= op_vld;
            if (op_vld) begin
                prod_dat <= (2*DATA_WIDTH)'(op_a) * (2*DATA_WIDTH)'(op_b);
            end
        end
    end

endmodule

// File: rtl/dot_product_mac.sv
// Pipelined signed dot-product MAC: one job = start+len, then len operand pairs, one result out.
// Latency: result valid 3 edges after the last accepted pair (multiply, accumulate, drain check).
// in_ready only in ACCUM while pairs remain; result held in DONE until out_ready.
// Optional build macro MAC_SATURATE_EN: saturate the accumulator instead of wrapping.
module dot_product_mac
    import dot_product_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_result,
    output logic                  overflow,
    output logic                  busy
);

`ifdef MAC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    mac_state_t                    state_q;
    mac_state_t                    state_d;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          cnt_q;
    logic                          job_start;
    logic                          accept;
    logic                          last_accept;

    logic                          s1_vld;
    logic signed [2*DATA_WIDTH-1:0] s1_prod;
    logic                          s2_vld;

    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   acc_nxt;
    logic                          add_ovf;
    logic                          ovf_q;

    assign job_start   = (state_q == ST_IDLE) && start;
    assign in_ready    = (state_q == ST_ACCUM) && (cnt_q < len_q);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && ((cnt_q + LEN_WIDTH'(1)) == len_q);

    // Next-state: job request, last pair accepted, pipeline drained, result consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_vld && !s2_vld) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job length latch and accepted-pair counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (job_start) begin
            len_q <= len;
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + LEN_WIDTH'(1);
        end
    end

    // Stage 1: registered product of each accepted pair.
    mac_mult_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk      (clk),
        .reset    (reset),
        .op_vld   (accept),
        .op_a     (in_a),
        .op_b     (in_b),
        .prod_vld (s1_vld),
        .prod_dat (s1_prod)
    );

    // Signed overflow: both addends share a sign and the sum's sign differs.
    assign prod_ext = ACC_WIDTH'(s1_prod);
    assign sum      = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]);

`ifdef MAC_SATURATE_EN
    // Clamp toward the side the addends were heading; a later term can pull it back in range.
    assign acc_nxt = add_ovf ? (acc_q[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign acc_nxt = sum;
`endif

    // Stage 2: accumulate, track sticky overflow, and a valid bit so DRAIN sees the add land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (job_start) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s1_vld) begin
                acc_q <= acc_nxt;
                if (add_ovf) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = (state_q == ST_DONE);
    assign out_result = acc_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac against an exact-arithmetic reference model.
// Directed jobs from the block's behaviour list plus randomized jobs with gaps and held results.
// Build with or without MAC_SATURATE_EN; the model follows the same macro.
module tb_dot_product_mac;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int LW = 8;
    localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MINV = -128'sh8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_result;
    logic          overflow;
    logic          busy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int pa [16];
    int pb [16];

    dot_product_mac #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact dot product with per-term range checks on a 128-bit running sum.
    task automatic model(input int n, output logic [63:0] res, output bit ov);
        logic signed [127:0] acc;
        logic signed [127:0] x;
        logic signed [127:0] y;
        logic signed [127:0] t;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < n; i++) begin
            x = pa[i];
            y = pb[i];
            t = acc + x * y;
            if (t > MAXV || t < MINV) begin
                ov = 1'b1;
`ifdef MAC_SATURATE_EN
                acc = (t > MAXV) ? MAXV : MINV;
`else
                acc = {{64{t[63]}}, t[63:0]};
`endif
            end else begin
                acc = t;
            end
        end
        res = acc[63:0];
    endtask

    // gap_mode: 0 back-to-back, 1 two idle cycles before each pair, 2 random 0..2.
    task automatic run_job(input int n, input int gap_mode, input int hold, input string tag);
        logic [63:0] exp_res;
        bit          exp_ov;
        int          last_edge;
        int          guard;
        int          g;
        model(n, exp_res, exp_ov);
        @(negedge clk);
        start = 1'b1;
        len   = LW'(n);
        @(negedge clk);
        start = 1'b0;
        len   = LW'($urandom);
        check({tag, " busy"}, 64'(busy), 64'd1);
        last_edge = cyc;
        if (n == 0) begin
            check({tag, " len0 in_ready"}, 64'(in_ready), 64'd0);
            check({tag, " len0 out_valid"}, 64'(out_valid), 64'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_a     = $urandom;
                    in_b     = $urandom;
                    @(negedge clk);
                end
                in_valid = 1'b1;
                in_a     = pa[i];
                in_b     = pb[i];
                guard    = 0;
                while (!in_ready && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 50) begin
                    check({tag, " in_ready timeout"}, 64'(in_ready), 64'd1);
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                last_edge = cyc;
            end
            in_valid = 1'b0;
            in_a     = $urandom;
            in_b     = $urandom;
            check({tag, " in_ready after last"}, 64'(in_ready), 64'd0);
            guard = 0;
            while (!out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check({tag, " out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " latency"}, 64'(cyc - last_edge), 64'd3);
        end
        check({tag, " result"}, out_result, exp_res);
        check({tag, " overflow"}, 64'(overflow), 64'(exp_ov));
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start     = (k == 1);
            len       = LW'($urandom);
            @(negedge clk);
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold result"}, out_result, exp_res);
        end
        // Handshake cycle with start also high: start must be ignored.
        out_ready = 1'b1;
        start     = 1'b1;
        len       = LW'(5);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", out_result, 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // (1,2),(3,4),(5,6) back to back.
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
        run_job(3, 0, 0, "basic3");
        check("basic3 const", out_result, 64'd44);

        // (-7,3),(2,-5) with two idle cycles before each pair.
        pa[0] = -7; pb[0] = 3; pa[1] = 2; pb[1] = -5;
        run_job(2, 1, 1, "gaps2");

        // Empty job.
        run_job(0, 0, 1, "len0");

        // Held result with start pulsed while out_ready is low.
        pa[0] = 11; pb[0] = -13; pa[1] = 100; pb[1] = 7;
        run_job(2, 0, 5, "hold5");

        // Four products of 2^62: wraps to 0, or saturates high.
        for (int i = 0; i < 4; i++) begin
            pa[i] = int'(32'h8000_0000);
            pb[i] = int'(32'h8000_0000);
        end
        run_job(4, 0, 0, "ovf4");
`ifdef MAC_SATURATE_EN
        check("ovf4 const", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        check("ovf4 const", out_result, 64'd0);
`endif
        check("ovf4 flag", 64'(overflow), 64'd1);
        @(negedge clk);

        // Reset in the middle of a 4-pair job after two pairs.
        start = 1'b1;
        len   = LW'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 32'd1000;
        in_b     = 32'd1000;
        @(negedge clk);
        in_a = 32'd2000;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd0);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_result", out_result, 64'd0);
        check("midrst overflow", 64'(overflow), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pa[0] = 9; pb[0] = 9;
        run_job(1, 0, 0, "after_rst");
        check("after_rst const", out_result, 64'd81);

        // Randomized jobs: mix of small and full-range operands, random gaps and hold.
        for (int j = 0; j < 8; j++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                if (j % 2 == 0) begin
                    pa[i] = int'($urandom_range(0, 400)) - 200;
                    pb[i] = int'($urandom_range(0, 400)) - 200;
                end else begin
                    pa[i] = int'($urandom);
                    pb[i] = int'($urandom);
                end
            end
            run_job(n, 2, int'($urandom_range(0, 3)), $sformatf("rand%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
